// File: rtl/dbi_decode_lanes.sv
// Multi-lane DBI decoder with a valid/ready handshake and a 2-entry output buffer.
// Define DBI_STATS_EN to enable the saturating inverted-lane counter (inv_cnt).
module dbi_decode_lanes #(
  parameter int bw = 16,
  parameter int LW = 8,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dbi_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [bw+(bw/LW)-1:0]  data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bw-1:0]          data_out,
  input  logic                   stats_clr,
  output logic [CW-1:0]          inv_cnt
);

  localparam int NL = bw / LW;

  if ((bw % LW) != 0 || bw < LW) begin : g_bad_params
    $error("dbi_decode_lanes: bw must be a positive integer multiple of LW");
  end

  logic [bw-1:0] decoded;
  logic [bw-1:0] mem [2];
  logic [bw-1:0] head;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          accept;
  logic          pop;

  always_comb begin
    decoded = data_in[bw-1:0];
    for (int k = 0; k < NL; k++) begin
      if (dbi_en && data_in[bw+k]) begin
        decoded[k*LW +: LW] = ~data_in[k*LW +: LW];
      end
    end
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign data_out  = head;

  // The head register mirrors the oldest entry so data_out holds its value when the buffer drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      head   <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= decoded;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && (count == 2'd0 || (pop && count == 2'd1))) begin
        head <= decoded;
      end else if (pop && count == 2'd2) begin
        head <= mem[~rd_ptr];
      end
    end
  end

`ifdef DBI_STATS_EN
  localparam int PW = $clog2(NL + 1);

  logic [PW-1:0] flag_cnt;
  logic [CW:0]   cnt_sum;
  logic [CW-1:0] cnt_q;

  always_comb begin
    flag_cnt = '0;
    if (dbi_en) begin
      for (int k = 0; k < NL; k++) begin
        flag_cnt = flag_cnt + PW'(data_in[bw+k]);
      end
    end
    cnt_sum = {1'b0, cnt_q} + (CW+1)'(flag_cnt);
  end

  // Clear wins over a same-cycle accept; the sum carries out into bit CW on overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (stats_clr) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
    end
  end

  assign inv_cnt = cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign inv_cnt = '0;
`endif

endmodule
